// File: rtl/uart_capture.sv
// UART receiver (one bit per clock, 8N1) with framing check, FWFT FIFO read port
// and an end-of-message pulse after a programmable idle gap.
module uart_capture #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IDLE_GAP   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          RXD,
  output logic [7:0]                    DATA,
  output logic                          VALID,
  input  logic                          READY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          FRAME_ERR,
  output logic                          OVERFLOW,
  input  logic                          CLR_OVF,
  output logic                          EOM
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned IW = $clog2(IDLE_GAP + 1);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic [IW-1:0] GAP     = IW'(IDLE_GAP);
  localparam logic [IW-1:0] GAP_M1  = IW'(IDLE_GAP - 1);
  localparam logic [IW-1:0] CNT_ONE = IW'(1);

  typedef enum logic [1:0] {ST_HUNT, ST_IDLE, ST_DATA, ST_STOP} state_t;

  state_t          state, state_nxt;
  logic            rxd_q;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [IW-1:0]   idle_cnt;
  logic            armed;
  logic            good_byte, bad_stop;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            full, push, pop, drop;

  always_ff @(posedge CLK) begin
    if (RESET) rxd_q <= 1'b1;
    else       rxd_q <= RXD;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    good_byte = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      ST_HUNT: if (rxd_q) state_nxt = ST_IDLE;
      ST_IDLE: if (!rxd_q) state_nxt = ST_DATA;
      ST_DATA: if (bit_cnt == 3'd7) state_nxt = ST_STOP;
      ST_STOP: begin
        if (rxd_q) begin
          good_byte = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          bad_stop  = 1'b1;
          state_nxt = ST_HUNT;
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  // LSB arrives first, so shifting in at the MSB leaves bit 0 in place after 8 shifts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state == ST_IDLE && !rxd_q) bit_cnt <= '0;
      if (state == ST_DATA) begin
        shreg   <= {rxd_q, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign LEVEL = wr_ptr - rd_ptr;
  assign VALID = (LEVEL != '0);
  assign full  = (LEVEL == DEPTH_L);
  assign pop   = VALID && READY;
  assign push  = good_byte && (!full || pop);
  assign drop  = good_byte && full && !pop;
  assign DATA  = VALID ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Dropped bytes still arm end-of-message; set beats clear on OVERFLOW.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FRAME_ERR <= 1'b0;
      OVERFLOW  <= 1'b0;
      EOM       <= 1'b0;
      armed     <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      FRAME_ERR <= bad_stop;
      if (drop)         OVERFLOW <= 1'b1;
      else if (CLR_OVF) OVERFLOW <= 1'b0;
      EOM <= 1'b0;
      if (state == ST_IDLE && rxd_q) begin
        if (idle_cnt != GAP) idle_cnt <= idle_cnt + CNT_ONE;
        if (armed && idle_cnt == GAP_M1) begin
          EOM   <= 1'b1;
          armed <= 1'b0;
        end
      end else begin
        idle_cnt <= '0;
      end
      if (good_byte) armed <= 1'b1;
    end
  end
endmodule
